aes_din_packer: RTL and testbench
=================================

Name: aes_din_packer

Overview:
- Input staging stage that sits directly upstream of the AES core's data input, inside the openMSP430 AES peripheral.
- Packs 16-bit words written by the CPU into 128-bit blocks, in little-endian word order.
- Queues completed blocks in a small FIFO.
- Issues each block to the core as a single-cycle valid pulse, only while the core reports ready.
- Lets software stream several blocks without polling the core between every block.

Parameters:
- DW, 16, peripheral word width; fixed at 16.
- BW, 128, AES block width; must equal 8*DW.
- NBUF, 2, depth of the completed-block FIFO; allowed 1..4.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  packer enable; when low, no blocks are issued, but words are still accepted
- clear  in  1  synchronous flush of the assembly register, the FIFO and the overflow flag
- wr_en  in  1  one-cycle word write strobe
- wr_data  in  DW  word to pack
- core_ready  in  1  AES core ready for the next block
- blk_data  out  BW  block presented to the core
- blk_valid  out  1  one-cycle issue pulse to the core
- word_cnt  out  3  words held in the assembly register (0..7)
- blk_cnt  out  3  completed blocks pending in the FIFO (0..NBUF)
- in_full  out  1  the next write cannot be accepted
- empty  out  1  word_cnt==0 and blk_cnt==0
- overflow  out  1  sticky: a write was dropped

Behaviour:
- Reset (asynchronous, reset_n low):
  - all storage cleared; blk_data=0, blk_valid=0, word_cnt=0, blk_cnt=0, overflow=0.
  - FSM returns to IDLE.
  - a partially assembled block is discarded.
- Packing:
  - word k of a block (k=word_cnt) is written to bits [16k+15:16k].
  - so the first word lands in [15:0] and the eighth in [127:112].
- Completion: the write with word_cnt==7 moves the completed 128-bit value into the FIFO tail, increments blk_cnt and wraps word_cnt to 0.
- in_full:
  - in_full = (blk_cnt==NBUF) && (word_cnt==7).
  - computed from registered state only; a pop in the same cycle does not make room.
- Overflow: wr_en while in_full drops the word, sets overflow and leaves word_cnt unchanged.
- Non-completing writes are always accepted, even when the FIFO is full.
- blk_data always shows the FIFO head; it is 0 when the FIFO is empty.
- blk_data is stable from the issue pulse until the pop takes effect.
- FSM states and transitions:
  - IDLE -> ISSUE when enable && blk_cnt>0 && core_ready.
  - ISSUE (one cycle):
    - blk_valid=1; the head is popped at the end of the cycle (blk_cnt-1).
    - blk_data shows the issued block during this cycle.
    - always -> HOLD.
  - HOLD (one cycle): core_ready is ignored, covering the core's one-cycle ready-drop latency; always -> IDLE.
  - Issue rate is therefore at most one block per 3 cycles.
- Simultaneous push and pop in one cycle: both take effect, and blk_cnt is unchanged.
- enable falling:
  - if it falls during ISSUE or HOLD, the sequence completes.
  - no new issue starts while enable is low.
- clear:
  - has priority over wr_en and over a pending pop.
  - empties the assembly register and the FIFO, clears overflow and returns to IDLE.
  - if clear arrives in ISSUE, blk_valid still completes its single cycle, but the pop is superseded by the flush.
- blk_valid is never high for two consecutive cycles.
- Pointer arithmetic: FIFO read and write pointers are modulo NBUF, with wrap-around tested at NBUF=2 and NBUF=3.

Decomposition:
- Shared package aes_pkg holds:
  - AES_BW=128 and AES_DW=16;
  - the FSM state encoding (IDLE, ISSUE, HOLD);
  - the per-word slice-index helper.
- One natural sub-module, aes_blk_fifo:
  - NBUF x BW storage with push, pop, count, head output and flush;
  - the packer FSM and assembly register stay in aes_din_packer.

Test Plan:
- Single block:
  - stimulus: enable=1, core_ready=1, write 0x0001..0x0008.
  - response: blk_valid pulses exactly once, 1 cycle after the 8th write, with blk_data=0x0008_0007_0006_0005_0004_0003_0002_0001; then blk_cnt=0 and empty=1.
- Backpressure and overflow:
  - stimulus: core_ready=0, NBUF=2, write 24 words.
  - response: blk_cnt=2, word_cnt=7, in_full=1; the 24th write is dropped, overflow=1, word_cnt stays 7.
  - then raise core_ready: two blk_valid pulses exactly 3 cycles apart, in write order.
- Simultaneous push and pop:
  - stimulus: blk_cnt=1 and the FSM in ISSUE, in the same cycle as an 8th-word write.
  - response: blk_cnt stays 1, and the next issue carries the newly completed block.
- Clear mid-stream:
  - stimulus: 5 words written plus 1 full block pending, enable=0, then pulse clear together with wr_en=1.
  - response: word_cnt=0, blk_cnt=0, overflow=0, the word is not stored, and no blk_valid follows.
- Asynchronous reset mid-operation:
  - stimulus: assert reset_n=0 during HOLD with 1 block pending.
  - response: all outputs 0 immediately; after release, writing 8 words produces a fresh, correct block.
- Enable gating:
  - stimulus: enable=0 with 2 blocks pending and core_ready=1.
  - response: no blk_valid while enable is low; after enable=1, two pulses 3 cycles apart.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES peripheral data-input path.
// Holds block/word widths, the packer FSM encoding and the word slice helper.
// No logic of its own; imported by the packer and its block FIFO.
package aes_pkg;

    localparam int AES_BW = 128;
    localparam int AES_DW = 16;

    // Issue sequencer: IDLE waits for a block and a ready core, ISSUE is the
    // single valid cycle, HOLD masks the core's one-cycle ready-drop latency.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } pk_state_e;

    // Lowest bit of word k inside a block (little-endian word order).
    function automatic int word_lsb(input logic [2:0] k);
        return int'(k) * AES_DW;
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Small FIFO of completed AES blocks, NBUF entries deep, with synchronous flush.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: a push into a full FIFO is ignored; flush overrides push and pop.
module aes_blk_fifo
    import aes_pkg::*;
#(
    parameter int BW   = AES_BW,
    parameter int NBUF = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic [BW-1:0] push_data,
    input  logic          pop,
    output logic [BW-1:0] head,
    output logic [2:0]    count
);

    localparam int PW = (NBUF > 1) ? $clog2(NBUF) : 1;

    logic [BW-1:0] mem_q [NBUF];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [2:0]    cnt_q;
    logic          do_push;
    logic          do_pop;

    // Pointers run modulo NBUF, which need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(NBUF - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !flush && (cnt_q != 3'(NBUF));
    assign do_pop  = pop && !flush && (cnt_q != 3'd0);

    // Storage, pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NBUF; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Stale entries are masked so an empty FIFO presents zero.
    assign head  = (cnt_q == 3'd0) ? '0 : mem_q[rd_ptr_q];
    assign count = cnt_q;

endmodule

// File: rtl/aes_din_packer.sv
// Packs CPU 16-bit words into 128-bit AES blocks and issues them to the core.
// Latency: a completed block issues 1 cycle after its last word; at most 1 block per 3 cycles.
// Backpressure: blocks wait in the FIFO while core_ready/enable are low; a completing write into a full FIFO is dropped and flagged.
module aes_din_packer
    import aes_pkg::*;
#(
    parameter int DW   = AES_DW,
    parameter int BW   = AES_BW,
    parameter int NBUF = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          clear,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          core_ready,
    output logic [BW-1:0] blk_data,
    output logic          blk_valid,
    output logic [2:0]    word_cnt,
    output logic [2:0]    blk_cnt,
    output logic          in_full,
    output logic          empty,
    output logic          overflow
);

    logic [BW-1:0] asm_q, asm_d;
    logic [2:0]    word_cnt_q, word_cnt_d;
    logic          ovf_q, ovf_d;
    pk_state_e     state_q, state_d;

    logic [BW-1:0] push_blk;
    logic [2:0]    fifo_cnt;
    logic          accept;
    logic          complete;
    logic          pop;

    // Only a completing write can be refused; the check uses registered state,
    // so a pop in the same cycle does not make room.
    assign in_full  = (fifo_cnt == 3'(NBUF)) && (word_cnt_q == 3'd7);
    assign accept   = wr_en && !clear && !in_full;
    assign complete = accept && (word_cnt_q == 3'd7);

    // Assembly register, word counter and sticky overflow; clear wins over writes.
    always_comb begin
        asm_d      = asm_q;
        word_cnt_d = word_cnt_q;
        ovf_d      = ovf_q;
        push_blk   = asm_q;
        push_blk[word_lsb(word_cnt_q) +: DW] = wr_data;
        if (clear) begin
            asm_d      = '0;
            word_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            if (wr_en && in_full) ovf_d = 1'b1;
            if (accept) begin
                asm_d      = complete ? '0 : push_blk;
                word_cnt_d = word_cnt_q + 3'd1;
            end
        end
    end

    // Issue sequencer; clear forces IDLE but lets a current valid cycle finish.
    always_comb begin
        state_d   = state_q;
        blk_valid = 1'b0;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE:  if (enable && (fifo_cnt != 3'd0) && core_ready) state_d = ST_ISSUE;
            ST_ISSUE: begin
                blk_valid = 1'b1;
                pop       = 1'b1;
                state_d   = ST_HOLD;
            end
            ST_HOLD:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (clear) state_d = ST_IDLE;
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_q      <= '0;
            word_cnt_q <= '0;
            ovf_q      <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            asm_q      <= asm_d;
            word_cnt_q <= word_cnt_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
        end
    end

    aes_blk_fifo #(
        .BW   (BW),
        .NBUF (NBUF)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (clear),
        .push      (complete),
        .push_data (push_blk),
        .pop       (pop),
        .head      (blk_data),
        .count     (fifo_cnt)
    );

    assign word_cnt = word_cnt_q;
    assign blk_cnt  = fifo_cnt;
    assign empty    = (word_cnt_q == 3'd0) && (fifo_cnt == 3'd0);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_aes_din_packer.sv
// Testbench for aes_din_packer: directed scenarios plus a randomized run.
// Reference model keeps partial words and completed blocks as queues.
// Issue timing is modelled as "at most one issue every 3 edges".
module tb_aes_din_packer;

    localparam int NBUF = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         enable = 1'b0;
    logic         clear = 1'b0;
    logic         wr_en = 1'b0;
    logic [15:0]  wr_data = '0;
    logic         core_ready = 1'b0;
    logic [127:0] blk_data;
    logic         blk_valid;
    logic [2:0]   word_cnt;
    logic [2:0]   blk_cnt;
    logic         in_full;
    logic         empty;
    logic         overflow;

    aes_din_packer #(.DW(16), .BW(128), .NBUF(NBUF)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .clear      (clear),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .core_ready (core_ready),
        .blk_data   (blk_data),
        .blk_valid  (blk_valid),
        .word_cnt   (word_cnt),
        .blk_cnt    (blk_cnt),
        .in_full    (in_full),
        .empty      (empty),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [15:0]  m_words[$];
    logic [127:0] m_blks[$];
    logic         m_ovf;
    int           edge_n = 0;
    int           last_start = -10;

    task automatic model_reset();
        m_words.delete();
        m_blks.delete();
        m_ovf      = 1'b0;
        last_start = -10;
    endtask

    // Applies the effect of one rising edge using the inputs held across it.
    task automatic model_edge();
        int pre_size;
        bit full;
        bit was_issue;
        logic [127:0] b;
        edge_n++;
        pre_size  = m_blks.size();
        full      = (pre_size == NBUF) && (m_words.size() == 7);
        was_issue = (last_start == edge_n - 1);
        if (clear) begin
            m_words.delete();
            m_blks.delete();
            m_ovf      = 1'b0;
            last_start = -10;
        end else begin
            if (was_issue && m_blks.size() > 0) void'(m_blks.pop_front());
            if (wr_en) begin
                if (full) m_ovf = 1'b1;
                else begin
                    m_words.push_back(wr_data);
                    if (m_words.size() == 8) begin
                        b = '0;
                        for (int i = 0; i < 8; i++) b[16*i +: 16] = m_words[i];
                        m_blks.push_back(b);
                        m_words.delete();
                    end
                end
            end
            if (enable && core_ready && pre_size > 0 && (edge_n - last_start) >= 3)
                last_start = edge_n;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
    endtask

    task automatic write_word(input logic [15:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        enable     = 1'b0;
        clear      = 1'b0;
        wr_en      = 1'b0;
        core_ready = 1'b0;
        reset_n    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [127:0] mk_blk(input logic [15:0] base);
        logic [127:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b[16*i +: 16] = base + 16'(i);
        return b;
    endfunction

    task automatic test_reset();
        do_reset();
        n_checks++; if (blk_data !== 128'd0) $display("FAIL reset_data: got %h want 0", blk_data); else n_pass++;
        n_checks++; if (blk_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", blk_valid); else n_pass++;
        n_checks++; if ({word_cnt, blk_cnt} !== 6'd0) $display("FAIL reset_cnts: got %0d/%0d want 0/0", word_cnt, blk_cnt); else n_pass++;
        n_checks++; if ({in_full, empty, overflow} !== 3'b010) $display("FAIL reset_flags: got %b want 010", {in_full, empty, overflow}); else n_pass++;
    endtask

    task automatic test_single_block();
        int pulses = 0;
        int first_at = -1;
        logic [127:0] got = '0;
        logic [127:0] exp_b = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        do_reset();
        enable = 1'b1;
        core_ready = 1'b1;
        for (int i = 1; i <= 8; i++) write_word(16'(i));
        n_checks++; if (blk_valid !== 1'b0 || blk_cnt !== 3'd1) $display("FAIL single_pre: got valid=%b cnt=%0d want 0/1", blk_valid, blk_cnt); else n_pass++;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (blk_valid) begin
                pulses++;
                if (first_at < 0) begin first_at = c; got = blk_data; end
            end
        end
        n_checks++; if (first_at !== 0) $display("FAIL single_when: got %0d want 0", first_at); else n_pass++;
        n_checks++; if (pulses !== 1) $display("FAIL single_pulses: got %0d want 1", pulses); else n_pass++;
        n_checks++; if (got !== exp_b) $display("FAIL single_data: got %h want %h", got, exp_b); else n_pass++;
        n_checks++; if (blk_cnt !== 3'd0 || empty !== 1'b1) $display("FAIL single_post: got cnt=%0d empty=%b want 0/1", blk_cnt, empty); else n_pass++;
    endtask

    task automatic test_backpressure();
        int at[$];
        logic [127:0] dat[$];
        do_reset();
        enable = 1'b1;
        core_ready = 1'b0;
        for (int i = 0; i < 23; i++) write_word(16'h0100 + 16'(i));
        n_checks++; if (blk_cnt !== 3'd2 || word_cnt !== 3'd7) $display("FAIL bp_cnts: got %0d/%0d want 2/7", blk_cnt, word_cnt); else n_pass++;
        n_checks++; if (in_full !== 1'b1 || overflow !== 1'b0) $display("FAIL bp_full: got full=%b ovf=%b want 1/0", in_full, overflow); else n_pass++;
        write_word(16'h01FF);
        n_checks++; if (overflow !== 1'b1 || word_cnt !== 3'd7 || blk_cnt !== 3'd2) $display("FAIL bp_ovf: got ovf=%b wc=%0d bc=%0d want 1/7/2", overflow, word_cnt, blk_cnt); else n_pass++;
        core_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (blk_valid) begin at.push_back(c); dat.push_back(blk_data); end
        end
        n_checks++; if (at.size() !== 2) $display("FAIL bp_npulse: got %0d want 2", at.size()); else n_pass++;
        if (at.size() >= 2) begin
            n_checks++; if (at[1] - at[0] !== 3) $display("FAIL bp_gap: got %0d want 3", at[1] - at[0]); else n_pass++;
            n_checks++; if (dat[0] !== mk_blk(16'h0100)) $display("FAIL bp_blk0: got %h want %h", dat[0], mk_blk(16'h0100)); else n_pass++;
            n_checks++; if (dat[1] !== mk_blk(16'h0108)) $display("FAIL bp_blk1: got %h want %h", dat[1], mk_blk(16'h0108)); else n_pass++;
        end
        n_checks++; if (blk_cnt !== 3'd0 || word_cnt !== 3'd7 || in_full !== 1'b0) $display("FAIL bp_after: got bc=%0d wc=%0d full=%b want 0/7/0", blk_cnt, word_cnt, in_full); else n_pass++;
    endtask

    task automatic test_push_pop();
        int found = -1;
        logic [127:0] got = '0;
        do_reset();
        enable = 1'b1;
        core_ready = 1'b0;
        for (int i = 0; i < 8; i++) write_word(16'h0200 + 16'(i));
        for (int i = 0; i < 7; i++) write_word(16'h0300 + 16'(i));
        n_checks++; if (blk_cnt !== 3'd1 || word_cnt !== 3'd7) $display("FAIL pp_pre: got %0d/%0d want 1/7", blk_cnt, word_cnt); else n_pass++;
        core_ready = 1'b1;
        tick();
        n_checks++; if (blk_valid !== 1'b1 || blk_data !== mk_blk(16'h0200)) $display("FAIL pp_issue: got v=%b d=%h want 1/%h", blk_valid, blk_data, mk_blk(16'h0200)); else n_pass++;
        write_word(16'h0307);
        n_checks++; if (blk_cnt !== 3'd1 || word_cnt !== 3'd0) $display("FAIL pp_cnt: got %0d/%0d want 1/0", blk_cnt, word_cnt); else n_pass++;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (blk_valid && found < 0) begin found = c; got = blk_data; end
        end
        n_checks++; if (found !== 1) $display("FAIL pp_when: got %0d want 1", found); else n_pass++;
        n_checks++; if (got !== mk_blk(16'h0300)) $display("FAIL pp_data: got %h want %h", got, mk_blk(16'h0300)); else n_pass++;
    endtask

    task automatic test_clear();
        int pulses = 0;
        do_reset();
        enable = 1'b0;
        core_ready = 1'b1;
        for (int i = 0; i < 13; i++) write_word(16'h0A00 + 16'(i));
        n_checks++; if (blk_cnt !== 3'd1 || word_cnt !== 3'd5) $display("FAIL clr_pre: got %0d/%0d want 1/5", blk_cnt, word_cnt); else n_pass++;
        clear = 1'b1;
        write_word(16'hABCD);
        clear = 1'b0;
        n_checks++; if (word_cnt !== 3'd0 || blk_cnt !== 3'd0) $display("FAIL clr_cnts: got %0d/%0d want 0/0", word_cnt, blk_cnt); else n_pass++;
        n_checks++; if (overflow !== 1'b0 || empty !== 1'b1 || blk_data !== 128'd0) $display("FAIL clr_state: got ovf=%b empty=%b d=%h want 0/1/0", overflow, empty, blk_data); else n_pass++;
        enable = 1'b1;
        for (int c = 0; c < 8; c++) begin tick(); if (blk_valid) pulses++; end
        n_checks++; if (pulses !== 0) $display("FAIL clr_nopulse: got %0d want 0", pulses); else n_pass++;
        // overflow flag must also be cleared
        enable = 1'b0;
        for (int i = 0; i < 24; i++) write_word(16'(i));
        n_checks++; if (overflow !== 1'b1) $display("FAIL clr_ovf_set: got %b want 1", overflow); else n_pass++;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++; if (overflow !== 1'b0 || blk_cnt !== 3'd0) $display("FAIL clr_ovf: got ovf=%b bc=%0d want 0/0", overflow, blk_cnt); else n_pass++;
    endtask

    task automatic test_async_reset();
        int found = -1;
        logic [127:0] got = '0;
        logic [127:0] exp_b = '0;
        do_reset();
        enable = 1'b1;
        core_ready = 1'b0;
        for (int i = 0; i < 16; i++) write_word(16'h0400 + 16'(i));
        core_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (blk_cnt !== 3'd1 || blk_valid !== 1'b0) $display("FAIL ar_hold: got bc=%0d v=%b want 1/0", blk_cnt, blk_valid); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        n_checks++; if (blk_data !== 128'd0 || blk_valid !== 1'b0) $display("FAIL ar_out: got d=%h v=%b want 0/0", blk_data, blk_valid); else n_pass++;
        n_checks++; if ({word_cnt, blk_cnt, overflow, in_full} !== 8'd0) $display("FAIL ar_cnts: got %0d/%0d/%b/%b want 0", word_cnt, blk_cnt, overflow, in_full); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            exp_b[16*i +: 16] = w;
            write_word(w);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            if (blk_valid && found < 0) begin found = c; got = blk_data; end
        end
        n_checks++; if (found !== 0 || got !== exp_b) $display("FAIL ar_fresh: got at=%0d d=%h want 0/%h", found, got, exp_b); else n_pass++;
    endtask

    task automatic test_enable_gating();
        int pulses = 0;
        int at[$];
        logic [127:0] dat[$];
        do_reset();
        enable = 1'b0;
        core_ready = 1'b1;
        for (int i = 0; i < 16; i++) write_word(16'h0500 + 16'(i));
        for (int c = 0; c < 6; c++) begin tick(); if (blk_valid) pulses++; end
        n_checks++; if (pulses !== 0 || blk_cnt !== 3'd2) $display("FAIL en_gate: got pulses=%0d bc=%0d want 0/2", pulses, blk_cnt); else n_pass++;
        enable = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (blk_valid) begin at.push_back(c); dat.push_back(blk_data); end
        end
        n_checks++; if (at.size() !== 2) $display("FAIL en_npulse: got %0d want 2", at.size()); else n_pass++;
        if (at.size() >= 2) begin
            n_checks++; if (at[1] - at[0] !== 3) $display("FAIL en_gap: got %0d want 3", at[1] - at[0]); else n_pass++;
            n_checks++; if (dat[0] !== mk_blk(16'h0500) || dat[1] !== mk_blk(16'h0508)) $display("FAIL en_data: got %h %h want %h %h", dat[0], dat[1], mk_blk(16'h0500), mk_blk(16'h0508)); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [127:0] exp_d;
        logic [2:0]   exp_bc;
        logic [2:0]   exp_wc;
        logic         exp_full;
        logic         prev_valid = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            wr_en      = ($urandom % 10) < 6;
            wr_data    = 16'($urandom);
            clear      = ($urandom % 100) == 0;
            core_ready = ($urandom % 10) < 7;
            enable     = ($urandom % 10) < 9;
            tick();
            exp_d    = (m_blks.size() > 0) ? m_blks[0] : 128'd0;
            exp_bc   = 3'(m_blks.size());
            exp_wc   = 3'(m_words.size());
            exp_full = (m_blks.size() == NBUF) && (m_words.size() == 7);
            n_checks++; if (blk_valid !== (last_start == edge_n)) $display("FAIL rnd_valid@%0d: got %b want %b", cyc, blk_valid, last_start == edge_n); else n_pass++;
            n_checks++; if (blk_data !== exp_d) $display("FAIL rnd_data@%0d: got %h want %h", cyc, blk_data, exp_d); else n_pass++;
            n_checks++; if (blk_cnt !== exp_bc || word_cnt !== exp_wc) $display("FAIL rnd_cnts@%0d: got %0d/%0d want %0d/%0d", cyc, blk_cnt, word_cnt, exp_bc, exp_wc); else n_pass++;
            n_checks++; if ({in_full, empty, overflow} !== {exp_full, (exp_bc == 0 && exp_wc == 0), m_ovf}) $display("FAIL rnd_flags@%0d: got %b want %b", cyc, {in_full, empty, overflow}, {exp_full, (exp_bc == 0 && exp_wc == 0), m_ovf}); else n_pass++;
            n_checks++; if (prev_valid && blk_valid) $display("FAIL rnd_b2b@%0d: got valid twice want once", cyc); else n_pass++;
            prev_valid = blk_valid;
        end
        wr_en = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_backpressure();
        test_push_pop();
        test_clear();
        test_async_reset();
        test_enable_gating();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
